// File: rtl/acia_pkg.sv
// rtl/acia_pkg.sv - shared types and frame-format helpers for the ACIA transmitter
// Purpose: tx state encoding, parity / transmitter-control codes, frame config
//          record, word-length and stop-length decoders.
package acia_pkg;

   localparam int TICK_W = 8;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP,
      TX_BREAK
   } tx_state_t;

   localparam logic [1:0] PAR_ODD   = 2'b00;
   localparam logic [1:0] PAR_EVEN  = 2'b01;
   localparam logic [1:0] PAR_MARK  = 2'b10;
   localparam logic [1:0] PAR_SPACE = 2'b11;

   localparam logic [1:0] TXC_OFF = 2'b00;
   localparam logic [1:0] TXC_IRQ = 2'b01;
   localparam logic [1:0] TXC_ON  = 2'b10;
   localparam logic [1:0] TXC_BRK = 2'b11;

   // Per-character format, frozen when the byte enters the shift register.
   typedef struct packed {
      logic [3:0]        wlen;
      logic              par_en;
      logic [TICK_W-1:0] stop_ticks;
   } tx_cfg_t;

   // ctrl[6:5]: 00=8, 01=7, 10=6, 11=5 data bits.
   function automatic logic [3:0] wordlen(input logic [1:0] wl_sel);
      return 4'd8 - {2'b00, wl_sel};
   endfunction

   // Stop length in baud ticks; ctrl[7] asks for two stop bits except for
   // 5N (1.5 bits) and 8-bit-with-parity (1 bit).
   function automatic logic [TICK_W-1:0] stop_ticks(input logic [7:0] ctrl,
                                                    input logic [7:0] cmd,
                                                    input int         oversample);
      logic [3:0] wl;
      int         t;
      wl = wordlen(ctrl[6:5]);
      if (!ctrl[7])
         t = oversample;
      else if (wl == 4'd5 && !cmd[5])
         t = oversample * 3 / 2;
      else if (wl == 4'd8 && cmd[5])
         t = oversample;
      else
         t = 2 * oversample;
      return t[TICK_W-1:0];
   endfunction

endpackage

// File: rtl/acia_bit_timer.sv
// rtl/acia_bit_timer.sv - baud-tick counter that marks the end of each serial bit
// Purpose: counts i_baud_tick; o_bit_end pulses on the i_target-th tick.
// Ports: i_clock, i_reset (async, high), i_restart (hold count at 0),
//        i_baud_tick, i_target (ticks per bit), o_bit_end (one-clock pulse).
module acia_bit_timer
   import acia_pkg::*;
(
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_restart,
   input  logic              i_baud_tick,
   input  logic [TICK_W-1:0] i_target,
   output logic              o_bit_end
);

   logic [TICK_W-1:0] r_count;
   logic              w_last;

   assign w_last    = (r_count == i_target - TICK_W'(1));
   assign o_bit_end = i_baud_tick & w_last & ~i_restart;

   // Wrapping on bit_end lets the next bit start at zero without a restart.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset)
         r_count <= '0;
      else if (i_restart || o_bit_end)
         r_count <= '0;
      else if (i_baud_tick)
         r_count <= r_count + TICK_W'(1);
   end

endmodule

// File: rtl/acia_tx_serializer.sv
// rtl/acia_tx_serializer.sv - 6551-style ACIA transmit holding/shift register and framer
// Purpose: holds one byte, shifts it out as start/data/parity/stop on o_txd.
// Ports: i_clock, i_reset (async, high), i_baud_tick (OVERSAMPLE x baud),
//        i_tx_data/i_tx_load (holding register write), i_ctrl/i_cmd (6551 regs),
//        i_cts_n (clear to send, low), o_txd, o_rts_n, o_tdre, o_tx_busy, o_tx_done.
module acia_tx_serializer
   import acia_pkg::*;
#(
   parameter int OVERSAMPLE = 16
)
(
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_baud_tick,
   input  logic [7:0] i_tx_data,
   input  logic       i_tx_load,
   input  logic [7:0] i_ctrl,
   input  logic [7:0] i_cmd,
   input  logic       i_cts_n,
   output logic       o_txd,
   output logic       o_rts_n,
   output logic       o_tdre,
   output logic       o_tx_busy,
   output logic       o_tx_done
);

   localparam logic [TICK_W-1:0] BIT_TICKS = TICK_W'(OVERSAMPLE);

   tx_state_t         r_state;
   tx_state_t         w_next;
   logic [7:0]        r_hold;
   logic [7:0]        r_shift;
   logic              r_tdre;
   tx_cfg_t           r_cfg;
   logic              r_par_bit;
   logic [2:0]        r_bitcnt;
   logic              r_tx_done;

   logic [1:0]        w_txc;
   logic              w_xfer;
   logic              w_take;
   logic              w_bit_end;
   logic              w_stop_end;
   logic              w_last_data;
   logic [TICK_W-1:0] w_target;
   logic [3:0]        w_new_wlen;
   logic [7:0]        w_mask;
   logic              w_xor;
   logic              w_par_bit;
   logic              w_unused;

   assign w_txc       = i_cmd[3:2];
   assign w_xfer      = ~r_tdre & ((w_txc == TXC_IRQ) | (w_txc == TXC_ON)) & ~i_cts_n;
   assign w_stop_end  = (r_state == TX_STOP) & w_bit_end;
   // A new character may start from IDLE or straight out of the last stop bit.
   assign w_take      = w_xfer & ((r_state == TX_IDLE) | w_stop_end);
   assign w_last_data = ({1'b0, r_bitcnt} == (r_cfg.wlen - 4'd1));
   assign w_target    = (r_state == TX_STOP) ? r_cfg.stop_ticks : BIT_TICKS;
   assign w_unused    = ^{i_ctrl[4:0], i_cmd[4], i_cmd[1:0]};

   acia_bit_timer u_bit_timer (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_restart   ((r_state == TX_IDLE) || (r_state == TX_BREAK)),
      .i_baud_tick (i_baud_tick),
      .i_target    (w_target),
      .o_bit_end   (w_bit_end)
   );

   // Parity is taken from the held byte at transfer, masked to the word length.
   assign w_new_wlen = wordlen(i_ctrl[6:5]);
   assign w_mask     = 8'hFF >> (4'd8 - w_new_wlen);
   assign w_xor      = ^(r_hold & w_mask);

   always_comb begin
      w_par_bit = 1'b0;
      case (i_cmd[7:6])
         PAR_ODD:   w_par_bit = ~w_xor;
         PAR_EVEN:  w_par_bit = w_xor;
         PAR_MARK:  w_par_bit = 1'b1;
         PAR_SPACE: w_par_bit = 1'b0;
         default:   w_par_bit = 1'b0;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset)
         r_state <= TX_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         TX_IDLE: begin
            if (w_txc == TXC_BRK)
               w_next = TX_BREAK;
            else if (w_xfer)
               w_next = TX_START;
         end
         TX_START:  if (w_bit_end) w_next = TX_DATA;
         TX_DATA: begin
            if (w_bit_end && w_last_data)
               w_next = r_cfg.par_en ? TX_PARITY : TX_STOP;
         end
         TX_PARITY: if (w_bit_end) w_next = TX_STOP;
         TX_STOP:   if (w_bit_end) w_next = w_xfer ? TX_START : TX_IDLE;
         TX_BREAK:  if (w_txc != TXC_BRK) w_next = TX_IDLE;
         default:   w_next = TX_IDLE;
      endcase
   end

   always_comb begin
      o_txd     = 1'b1;
      o_tx_busy = 1'b0;
      case (r_state)
         TX_START:  begin o_txd = 1'b0;       o_tx_busy = 1'b1; end
         TX_DATA:   begin o_txd = r_shift[0]; o_tx_busy = 1'b1; end
         TX_PARITY: begin o_txd = r_par_bit;  o_tx_busy = 1'b1; end
         TX_STOP:   begin o_txd = 1'b1;       o_tx_busy = 1'b1; end
         TX_BREAK:  o_txd = 1'b0;
         default:   o_txd = 1'b1;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_hold    <= '0;
         r_shift   <= '0;
         r_tdre    <= 1'b1;
         r_cfg     <= '0;
         r_par_bit <= 1'b0;
         r_bitcnt  <= '0;
         r_tx_done <= 1'b0;
      end else begin
         r_tx_done <= w_stop_end;
         if (i_tx_load)
            r_hold <= i_tx_data;
         // A load on the transfer edge refills the holding register, so tdre stays low.
         if (i_tx_load)
            r_tdre <= 1'b0;
         else if (w_take)
            r_tdre <= 1'b1;
         if (w_take) begin
            r_shift   <= r_hold;
            r_cfg     <= '{wlen:       w_new_wlen,
                           par_en:     i_cmd[5],
                           stop_ticks: stop_ticks(i_ctrl, i_cmd, OVERSAMPLE)};
            r_par_bit <= w_par_bit;
            r_bitcnt  <= '0;
         end else if (r_state == TX_DATA && w_bit_end) begin
            r_shift  <= {1'b0, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
         end
      end
   end

   assign o_rts_n   = i_reset | (w_txc == TXC_OFF);
   assign o_tdre    = r_tdre;
   assign o_tx_done = r_tx_done;

endmodule
